// File: rtl/sd_read_scheduler.sv
// Multi-block SD read sequencer: issues one single-block read per block through the
// SPI block engine, gated on downstream FIFO space, with byte-count and timeout checks.
module sd_read_scheduler #(
   parameter int unsigned FIFO_DEPTH     = 1024,
   parameter int unsigned BLOCK_BYTES    = 512,
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned FC_W           = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_sector,
   input  logic [CNT_W-1:0] req_count,
   output logic             rd_start,
   output logic [31:0]      rd_address,
   input  logic             rd_busy,
   input  logic             rd_byte_valid,
   input  logic [FC_W-1:0]  fifo_count,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] blocks_done
);

   localparam int unsigned BC_W        = $clog2(BLOCK_BYTES + 2);
   localparam int unsigned TM_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SPACE_LIMIT = FIFO_DEPTH - BLOCK_BYTES;

   localparam logic [BC_W-1:0] BYTE_FULL = BC_W'(BLOCK_BYTES);
   localparam logic [BC_W-1:0] BYTE_SAT  = BC_W'(BLOCK_BYTES + 1);
   localparam logic [TM_W-1:0] TM_LAST   = TM_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_WAIT_SPACE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE, S_ERR
   } state_t;

   state_t            state, state_d;
   logic [31:0]       sector_q;
   logic [CNT_W-1:0]  count_q;
   logic [BC_W-1:0]   byte_cnt, byte_inc;
   logic [TM_W-1:0]   timer;
   logic              accept_c, blk_ok_c, timer_clr_c, timeout_c, space_ok_c;

   assign timeout_c  = (timer == TM_LAST);
   assign space_ok_c = (32'(fifo_count) <= SPACE_LIMIT);
   // Byte counter saturates one past a full block so overruns stay distinguishable.
   assign byte_inc   = (byte_cnt == BYTE_SAT) ? byte_cnt : byte_cnt + BC_W'(rd_byte_valid);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d     = state;
      accept_c    = 1'b0;
      blk_ok_c    = 1'b0;
      timer_clr_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept_c = 1'b1;
               state_d  = S_CHECK;
            end
         end
         S_CHECK:      state_d = (blocks_done == count_q) ? S_DONE : S_WAIT_SPACE;
         S_WAIT_SPACE: if (space_ok_c) state_d = S_ISSUE;
         S_ISSUE:      state_d = S_WAIT_HI;
         S_WAIT_HI: begin
            if (rd_busy) begin
               timer_clr_c = 1'b1;
               state_d     = S_WAIT_LO;
            end else if (timeout_c) begin
               state_d = S_ERR;
            end
         end
         S_WAIT_LO: begin
            if (!rd_busy) begin
               if (byte_inc == BYTE_FULL) begin
                  blk_ok_c = 1'b1;
                  state_d  = S_CHECK;
               end else begin
                  state_d = S_ERR;
               end
            end else if (timeout_c) begin
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, block bookkeeping, timer and byte counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         sector_q    <= '0;
         count_q     <= '0;
         blocks_done <= '0;
         byte_cnt    <= '0;
         timer       <= '0;
      end else begin
         if (accept_c) begin
            sector_q    <= req_sector;
            count_q     <= req_count;
            blocks_done <= '0;
         end else if (blk_ok_c) begin
            blocks_done <= blocks_done + CNT_W'(1);
         end

         if (accept_c || state == S_ISSUE) byte_cnt <= '0;
         else if (state == S_WAIT_LO)      byte_cnt <= byte_inc;

         if (state == S_ISSUE || timer_clr_c)                timer <= '0;
         else if (state == S_WAIT_HI || state == S_WAIT_LO)  timer <= timer + TM_W'(1);
      end
   end

   // Outputs registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         req_ready  <= 1'b1;
         rd_start   <= 1'b0;
         rd_address <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         req_ready <= (state_d == S_IDLE);
         rd_start  <= (state_d == S_ISSUE);
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_DONE);
         if (state_d == S_ISSUE)
            rd_address <= 32'((sector_q + 32'(blocks_done)) * BLOCK_BYTES);
         if (accept_c)               error <= 1'b0;
         else if (state_d == S_ERR)  error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sd_read_scheduler.sv
// Directed bench for sd_read_scheduler with an inline single-block engine model.
module tb_sd_read_scheduler;

   localparam int unsigned CNT_W = 20;
   localparam int unsigned FC_W  = 11;
   localparam int unsigned TMO   = 1024;

   logic             clock = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_sector;
   logic [CNT_W-1:0] req_count;
   logic             rd_start;
   logic [31:0]      rd_address;
   logic             rd_busy;
   logic             rd_byte_valid;
   logic [FC_W-1:0]  fifo_count;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] blocks_done;

   int n_tests = 0;
   int n_fail  = 0;
   int start_cnt = 0;
   int done_cnt  = 0;

   always #5 clock = ~clock;

   sd_read_scheduler #(
      .FIFO_DEPTH(1024), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(TMO),
      .CNT_W(CNT_W), .FC_W(FC_W)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_sector(req_sector), .req_count(req_count),
      .rd_start(rd_start), .rd_address(rd_address),
      .rd_busy(rd_busy), .rd_byte_valid(rd_byte_valid),
      .fifo_count(fifo_count),
      .busy(busy), .done(done), .error(error), .blocks_done(blocks_done)
   );

   always @(negedge clock) begin
      if (rd_start) start_cnt <= start_cnt + 1;
      if (done)     done_cnt  <= done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic request(input logic [31:0] sec, input logic [CNT_W-1:0] cnt);
      req_sector = sec;
      req_count  = cnt;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic wait_start(input string tag, output int waited);
      waited = 0;
      while (!rd_start && waited < 200) begin
         tick();
         waited++;
      end
      check({tag, "_start"}, 64'(rd_start), 64'd1);
   endtask

   // Engine model: busy rises the cycle after the start pulse is seen, then nbytes strobes.
   task automatic run_block(input string tag, input logic [31:0] addr, input int nbytes,
                            input bit merge, output int waited);
      wait_start(tag, waited);
      check({tag, "_addr"}, 64'(rd_address), 64'(addr));
      tick();
      check({tag, "_pulse"}, 64'(rd_start), 64'd0);
      rd_busy = 1'b1;
      tick();
      for (int i = 0; i < nbytes; i++) begin
         rd_byte_valid = 1'b1;
         if (merge && i == nbytes - 1) rd_busy = 1'b0;
         tick();
      end
      rd_byte_valid = 1'b0;
      check({tag, "_hold"}, 64'(rd_address), 64'(addr));
      if (!merge || nbytes == 0) begin
         rd_busy = 1'b0;
         tick();
      end
      rd_busy = 1'b0;
   endtask

   initial begin
      int w, s0, d0, n;
      reset = 1'b1; req_valid = 1'b0; req_sector = '0; req_count = '0;
      rd_busy = 1'b0; rd_byte_valid = 1'b0; fifo_count = '0;
      repeat (3) tick();
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_start", 64'(rd_start), 64'd0);
      check("rst_addr",  64'(rd_address), 64'd0);
      check("rst_flags", 64'({done, error}), 64'd0);
      check("rst_blocks", 64'(blocks_done), 64'd0);
      reset = 1'b0;
      tick();

      // Two good blocks from sector 0.
      s0 = start_cnt;
      request(32'd0, CNT_W'(2));
      check("t1_busy", 64'({busy, req_ready}), 64'b10);
      run_block("t1b0", 32'h0000_0000, 512, 1'b0, w);
      check("t1_lat0", 64'(w), 64'd2);
      check("t1_blk1", 64'(blocks_done), 64'd1);
      run_block("t1b1", 32'h0000_0200, 512, 1'b1, w);
      check("t1_lat1", 64'(w), 64'd2);
      tick();
      check("t1_done", 64'({done, error, busy}), 64'b101);
      check("t1_blocks", 64'(blocks_done), 64'd2);
      tick();
      check("t1_idle", 64'({done, busy, req_ready}), 64'b001);
      check("t1_starts", 64'(start_cnt - s0), 64'd2);

      // Zero-block request completes with no engine activity.
      s0 = start_cnt;
      request(32'd5, CNT_W'(0));
      tick();
      check("t2_done", 64'(done), 64'd1);
      tick();
      check("t2_idle", 64'({done, busy}), 64'd0);
      check("t2_starts", 64'(start_cnt - s0), 64'd0);

      // Back-pressure: 424 bytes free holds off, exactly 512 free releases.
      fifo_count = FC_W'(600);
      s0 = start_cnt;
      request(32'd3, CNT_W'(1));
      repeat (50) tick();
      check("t3_hold", 64'(start_cnt - s0), 64'd0);
      check("t3_hold_now", 64'({rd_start, busy}), 64'b01);
      fifo_count = FC_W'(512);
      run_block("t3", 32'h0000_0600, 512, 1'b0, w);
      check("t3_lat", 64'(w), 64'd1);
      fifo_count = '0;
      tick();
      check("t3_done", 64'(done), 64'd1);
      tick();

      // Short block aborts the request; next accept clears the error.
      d0 = done_cnt;
      request(32'd10, CNT_W'(3));
      run_block("t4", 32'h0000_1400, 511, 1'b0, w);
      check("t4_err", 64'({error, busy}), 64'b11);
      check("t4_blocks", 64'(blocks_done), 64'd0);
      tick();
      check("t4_idle", 64'({error, busy, req_ready}), 64'b101);
      check("t4_nodone", 64'(done_cnt - d0), 64'd0);
      request(32'd0, CNT_W'(0));
      check("t4_clr", 64'(error), 64'd0);
      repeat (2) tick();

      // Overlong block (513 bytes) is also an error.
      request(32'd20, CNT_W'(1));
      run_block("t4b", 32'h0000_2800, 513, 1'b0, w);
      check("t4b_err", 64'(error), 64'd1);
      tick();

      // Engine never raises busy: timeout after TMO cycles in WAIT_HI.
      request(32'd0, CNT_W'(1));
      wait_start("t5", w);
      n = 0;
      while (!error && n < 3000) begin
         tick();
         n++;
      end
      check("t5_tmo", 64'(n), 64'(TMO + 1));
      check("t5_busy_err", 64'(busy), 64'd1);
      tick();
      check("t5_idle", 64'({busy, error}), 64'b01);

      // Address wrap, then reset in the middle of block 2.
      request(32'h007F_FFFF, CNT_W'(2));
      run_block("t6b0", 32'hFFFF_FE00, 512, 1'b1, w);
      wait_start("t6b1", w);
      check("t6b1_addr", 64'(rd_address), 64'h0);
      tick();
      rd_busy = 1'b1;
      tick();
      rd_byte_valid = 1'b1;
      repeat (10) tick();
      check("t6_midblk", 64'({busy, blocks_done}), {43'd0, 1'b1, 20'd1});
      reset = 1'b1;
      tick();
      rd_busy = 1'b0; rd_byte_valid = 1'b0;
      check("t6_rst_ready", 64'(req_ready), 64'd1);
      check("t6_rst_busy", 64'({busy, rd_start, done, error}), 64'd0);
      check("t6_rst_blocks", 64'(blocks_done), 64'd0);
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
